// File: rtl/demux_deser_1x8.sv
// Serial-to-parallel receiver: each accepted bit is demuxed into the staging slot
// selected by the bit-index counter, and completed words are offered on valid/ready.
module demux_deser_1x8 #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             SIN_VALID,
    input  logic             SYNC,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic [IDX_W-1:0] BIT_IDX,
    output logic             BUSY,
    output logic             OVERRUN
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_stage;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;

    logic             w_accept;
    logic             w_last;
    logic             w_complete;

    // Handshake and frame-completion decode
    always_comb begin
        w_accept   = 1'b0;
        w_last     = 1'b0;
        w_complete = 1'b0;
        if (r_dout_valid && DOUT_READY) begin
            w_accept = 1'b1;
        end else begin
            w_accept = 1'b0;
        end
        if (r_idx == IDX_W'(WIDTH - 1)) begin
            w_last = 1'b1;
        end else begin
            w_last = 1'b0;
        end
        if (SIN_VALID && !SYNC && w_last) begin
            w_complete = 1'b1;
        end else begin
            w_complete = 1'b0;
        end
    end

    // Receiver state, staging register and output word
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_stage      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // Output side: a completion refills DOUT, otherwise acceptance drains it
            if (w_complete) begin
                r_dout       <= {SIN, r_stage[WIDTH-2:0]};
                r_dout_valid <= 1'b1;
                if (r_dout_valid && !DOUT_READY) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_accept) begin
                r_dout_valid <= 1'b0;
            end

            if (SYNC) begin
                r_overrun <= 1'b0;
                if (SIN_VALID) begin
                    r_stage <= {{(WIDTH-1){1'b0}}, SIN};
                    r_idx   <= IDX_W'(1);
                    r_state <= ST_RECV;
                end else begin
                    r_stage <= '0;
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end
            end else if (SIN_VALID) begin
                if (w_last) begin
                    r_stage <= '0;
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end else begin
                    r_stage[r_idx] <= SIN;
                    r_idx          <= r_idx + IDX_W'(1);
                    r_state        <= ST_RECV;
                end
            end
        end
    end

    assign DOUT       = r_dout;
    assign DOUT_VALID = r_dout_valid;
    assign BIT_IDX    = r_idx;
    assign BUSY       = (r_state == ST_RECV);
    assign OVERRUN    = r_overrun;

endmodule

// File: tb/tb_demux_deser_1x8.sv
// Directed bench for demux_deser_1x8: each task drives one scenario and checks
// against hand-computed words.
module tb_demux_deser_1x8;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SIN = 1'b0;
    logic       SIN_VALID = 1'b0;
    logic       SYNC = 1'b0;
    logic [7:0] DOUT;
    logic       DOUT_VALID;
    logic       DOUT_READY = 1'b0;
    logic [2:0] BIT_IDX;
    logic       BUSY;
    logic       OVERRUN;

    int checks = 0;
    int passes = 0;

    demux_deser_1x8 dut (
        .CLK(CLK), .RST(RST), .SIN(SIN), .SIN_VALID(SIN_VALID), .SYNC(SYNC),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
        .BIT_IDX(BIT_IDX), .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after a rising edge and are sampled there too.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        SIN = b;
        SIN_VALID = 1'b1;
        tick();
        SIN_VALID = 1'b0;
        SIN = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic accept_cycle();
        DOUT_READY = 1'b1;
        tick();
        DOUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if ({DOUT, DOUT_VALID, BIT_IDX, BUSY, OVERRUN} !== 14'd0) begin
            $display("FAIL reset_state: got dout=%h v=%b idx=%0d busy=%b ovr=%b, want all 0",
                     DOUT, DOUT_VALID, BIT_IDX, BUSY, OVERRUN);
        end else passes++;
    endtask

    task automatic test_basic_55();
        logic [7:0] bits;
        bits = 8'h55;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (BIT_IDX !== 3'(k) || BUSY !== (k != 0)) begin
                $display("FAIL basic_idx_step%0d: got idx=%0d busy=%b, want idx=%0d busy=%b",
                         k, BIT_IDX, BUSY, k, (k != 0));
            end else passes++;
            send_bit(bits[k]);
        end
        checks++;
        if (DOUT !== 8'h55 || DOUT_VALID !== 1'b1 || BIT_IDX !== 3'd0 || BUSY !== 1'b0) begin
            $display("FAIL basic_55: got dout=%h v=%b idx=%0d busy=%b, want 55 1 0 0",
                     DOUT, DOUT_VALID, BIT_IDX, BUSY);
        end else passes++;
    endtask

    task automatic test_gap_a5();
        logic [7:0] bits;
        bits = 8'hA5;
        accept_cycle();
        checks++;
        if (DOUT_VALID !== 1'b0 || DOUT !== 8'h55) begin
            $display("FAIL gap_pre_accept: got v=%b dout=%h, want 0 55", DOUT_VALID, DOUT);
        end else passes++;
        for (int k = 0; k < 3; k++) send_bit(bits[k]);
        for (int g = 0; g < 3; g++) begin
            tick();
            checks++;
            if (BIT_IDX !== 3'd3 || BUSY !== 1'b1) begin
                $display("FAIL gap_frozen%0d: got idx=%0d busy=%b, want 3 1", g, BIT_IDX, BUSY);
            end else passes++;
        end
        for (int k = 3; k < 8; k++) send_bit(bits[k]);
        checks++;
        if (DOUT !== 8'hA5 || DOUT_VALID !== 1'b1 || OVERRUN !== 1'b0) begin
            $display("FAIL gap_a5: got dout=%h v=%b ovr=%b, want a5 1 0", DOUT, DOUT_VALID, OVERRUN);
        end else passes++;
        accept_cycle();
        checks++;
        if (DOUT_VALID !== 1'b0 || DOUT !== 8'hA5) begin
            $display("FAIL gap_accept: got v=%b dout=%h, want 0 a5", DOUT_VALID, DOUT);
        end else passes++;
    endtask

    task automatic test_overrun();
        send_byte(8'h0F);
        checks++;
        if (DOUT !== 8'h0F || DOUT_VALID !== 1'b1 || OVERRUN !== 1'b0) begin
            $display("FAIL ovr_first: got dout=%h v=%b ovr=%b, want 0f 1 0", DOUT, DOUT_VALID, OVERRUN);
        end else passes++;
        send_byte(8'hF0);
        checks++;
        if (DOUT !== 8'hF0 || DOUT_VALID !== 1'b1 || OVERRUN !== 1'b1) begin
            $display("FAIL ovr_second: got dout=%h v=%b ovr=%b, want f0 1 1", DOUT, DOUT_VALID, OVERRUN);
        end else passes++;
        tick();
        checks++;
        if (OVERRUN !== 1'b1) begin
            $display("FAIL ovr_sticky: got ovr=%b, want 1", OVERRUN);
        end else passes++;
        SYNC = 1'b1;
        tick();
        SYNC = 1'b0;
        checks++;
        if (OVERRUN !== 1'b0 || DOUT !== 8'hF0 || DOUT_VALID !== 1'b1 || BIT_IDX !== 3'd0) begin
            $display("FAIL ovr_sync_clear: got ovr=%b dout=%h v=%b idx=%0d, want 0 f0 1 0",
                     OVERRUN, DOUT, DOUT_VALID, BIT_IDX);
        end else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        accept_cycle();
        send_byte(8'hC3);
        checks++;
        if (DOUT !== 8'hC3 || DOUT_VALID !== 1'b1) begin
            $display("FAIL b2b_old: got dout=%h v=%b, want c3 1", DOUT, DOUT_VALID);
        end else passes++;
        bits = 8'h3C;
        for (int k = 0; k < 7; k++) send_bit(bits[k]);
        DOUT_READY = 1'b1;
        send_bit(bits[7]);
        DOUT_READY = 1'b0;
        checks++;
        if (DOUT !== 8'h3C || DOUT_VALID !== 1'b1 || OVERRUN !== 1'b0) begin
            $display("FAIL b2b_new: got dout=%h v=%b ovr=%b, want 3c 1 0", DOUT, DOUT_VALID, OVERRUN);
        end else passes++;
        accept_cycle();
    endtask

    task automatic test_sync_realign();
        for (int k = 0; k < 5; k++) send_bit(1'b1);
        checks++;
        if (BIT_IDX !== 3'd5) begin
            $display("FAIL sync_pre_idx: got idx=%0d, want 5", BIT_IDX);
        end else passes++;
        SYNC = 1'b1;
        send_bit(1'b1);
        SYNC = 1'b0;
        checks++;
        if (BIT_IDX !== 3'd1 || BUSY !== 1'b1 || DOUT_VALID !== 1'b0) begin
            $display("FAIL sync_bit0: got idx=%0d busy=%b v=%b, want 1 1 0", BIT_IDX, BUSY, DOUT_VALID);
        end else passes++;
        for (int k = 0; k < 7; k++) send_bit(1'b0);
        checks++;
        if (DOUT !== 8'h01 || DOUT_VALID !== 1'b1 || BUSY !== 1'b0) begin
            $display("FAIL sync_word: got dout=%h v=%b busy=%b, want 01 1 0", DOUT, DOUT_VALID, BUSY);
        end else passes++;
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 4; k++) send_bit(1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if ({DOUT, DOUT_VALID, BIT_IDX, BUSY, OVERRUN} !== 14'd0) begin
            $display("FAIL rst_mid_clear: got dout=%h v=%b idx=%0d busy=%b ovr=%b, want all 0",
                     DOUT, DOUT_VALID, BIT_IDX, BUSY, OVERRUN);
        end else passes++;
        send_byte(8'hFF);
        checks++;
        if (DOUT !== 8'hFF || DOUT_VALID !== 1'b1 || OVERRUN !== 1'b0) begin
            $display("FAIL rst_mid_ff: got dout=%h v=%b ovr=%b, want ff 1 0", DOUT, DOUT_VALID, OVERRUN);
        end else passes++;
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_55();
        test_gap_a5();
        test_overrun();
        test_back_to_back();
        test_sync_realign();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, want finish before 100000");
        $fatal(1);
    end

endmodule
